// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, instruction field positions and controller states shared by exec_ctrl and the ALU.
package exec_pkg;
  localparam int DATA_WIDTH = 8;
  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_ORR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;
  localparam int OP_MSB = 15;
  localparam int RD_MSB = 12;
  localparam int RS1_MSB = 10;
  localparam int IMM_SEL_BIT = 8;
  localparam int IMM_MSB = 7;
  localparam int SGN_BIT = 2;
  localparam int RS2_MSB = 1;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  function automatic logic is_alu(input logic [2:0] op);
    return op != OP_LDI && op != OP_ILL;
  endfunction
endpackage

// File: rtl/exec_ctrl_if.sv
// exec_ctrl_if: instruction handshake, ALU bus, status and debug port of exec_ctrl.
interface exec_ctrl_if;
  import exec_pkg::*;
  logic instr_valid;
  logic [15:0] instr;
  logic instr_ready;
  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [2:0] alu_operation;
  logic alu_is_signed;
  logic [DATA_WIDTH-1:0] alu_result;
  logic alu_zero;
  logic done;
  logic err;
  logic flag_z;
  logic [1:0] dbg_sel;
  logic [DATA_WIDTH-1:0] dbg_data;
  modport slave(
    input instr_valid, instr, alu_result, alu_zero, dbg_sel,
    output instr_ready, alu_op1, alu_op2, alu_operation, alu_is_signed, done, err, flag_z, dbg_data
  );
  modport master(
    output instr_valid, instr, alu_result, alu_zero, dbg_sel,
    input instr_ready, alu_op1, alu_op2, alu_operation, alu_is_signed, done, err, flag_z, dbg_data
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: 4x8 register file, two async read ports plus debug read, one sync write port.
// EXEC_CTRL_R0_ZERO_EN makes R0 a hardwired zero (reads 0, writes dropped).
module reg_file
  import exec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [1:0] ra1,
  input  logic [1:0] ra2,
  input  logic [1:0] dsel,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [DATA_WIDTH-1:0] dd
);
`ifdef EXEC_CTRL_R0_ZERO_EN
  localparam bit r0_zero = 1'b1;
`else
  localparam bit r0_zero = 1'b0;
`endif
  logic [DATA_WIDTH-1:0] r [4];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else if (we && !(r0_zero && wa == 2'd0)) begin
      r[wa] <= wd;
    end
  end
  assign rd1 = (r0_zero && ra1 == 2'd0) ? '0 : r[ra1];
  assign rd2 = (r0_zero && ra2 == 2'd0) ? '0 : r[ra2];
  assign dd = (r0_zero && dsel == 2'd0) ? '0 : r[dsel];
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: 4-cycle IDLE/READ/EXEC/WB controller driving an external 8-bit ALU and writing back results.
// Optional EXEC_CTRL_R0_ZERO_EN (handled in reg_file) hardwires R0 to zero.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  exec_ctrl_if.slave bus
);
  state_t state;
  logic [15:0] ir;
  logic [DATA_W-1:0] res;
  logic zq;
  logic [DATA_W-1:0] rd1, rd2;
  logic [2:0] op;
  logic isel;
  logic [DATA_W-1:0] imm;
  assign op = ir[OP_MSB -: 3];
  assign isel = ir[IMM_SEL_BIT];
  assign imm = ir[IMM_MSB -: 8];
  reg_file u_rf (
    .clk(clk),
    .rst(rst),
    .we(state == WB && op != OP_ILL),
    .wa(ir[RD_MSB -: 2]),
    .wd(op == OP_LDI ? imm : res),
    .ra1(ir[RS1_MSB -: 2]),
    .ra2(ir[RS2_MSB -: 2]),
    .dsel(bus.dbg_sel),
    .rd1(rd1),
    .rd2(rd2),
    .dd(bus.dbg_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ir <= '0;
      res <= '0;
      zq <= 1'b0;
      bus.alu_op1 <= '0;
      bus.alu_op2 <= '0;
      bus.alu_operation <= '0;
      bus.alu_is_signed <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.flag_z <= 1'b0;
      bus.instr_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.instr_valid) begin
          ir <= bus.instr;
          bus.instr_ready <= 1'b0;
          state <= READ;
        end
        READ: begin
          bus.alu_op1 <= rd1;
          bus.alu_op2 <= isel ? imm : rd2;
          bus.alu_operation <= op;
          bus.alu_is_signed <= isel ? 1'b0 : ir[SGN_BIT];
          state <= EXEC;
        end
        EXEC: begin
          res <= bus.alu_result;
          zq <= bus.alu_zero;
          bus.done <= 1'b1;
          bus.err <= op == OP_ILL;
          state <= WB;
        end
        WB: begin
          if (is_alu(op)) bus.flag_z <= zq;
          bus.done <= 1'b0;
          bus.err <= 1'b0;
          bus.instr_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
